// File: rtl/xvec2_md_arbiter.sv
// xvec2_md_arbiter: shares one xvec2_vscale_mul_div unit between the core
// pipeline (port 0) and the vector coprocessor (port 1). One operation is in
// flight at a time; a watchdog forces completion if the unit never answers.
// Optional feature macro: XVEC2_MD_ARB_FIXED_PRIO_EN (port 0 always wins,
// no round-robin pointer). Default build is round-robin.

`ifndef VEC_XPR_LEN
`define VEC_XPR_LEN 64
`endif
`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`endif
`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`endif

module xvec2_md_arbiter #(
  parameter int unsigned WDT_CYCLES = 64,
  parameter int unsigned WDT_WIDTH  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic                          req0_in_1_signed,
  input  logic                          req0_in_2_signed,
  input  logic [`MD_OP_WIDTH-1:0]       req0_op,
  input  logic [`MD_OUT_SEL_WIDTH-1:0]  req0_out_sel,
  input  logic [`VEC_XPR_LEN-1:0]       req0_in_1,
  input  logic [`VEC_XPR_LEN-1:0]       req0_in_2,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic                          req1_in_1_signed,
  input  logic                          req1_in_2_signed,
  input  logic [`MD_OP_WIDTH-1:0]       req1_op,
  input  logic [`MD_OUT_SEL_WIDTH-1:0]  req1_out_sel,
  input  logic [`VEC_XPR_LEN-1:0]       req1_in_1,
  input  logic [`VEC_XPR_LEN-1:0]       req1_in_2,
  output logic                          resp0_valid,
  output logic [`VEC_XPR_LEN-1:0]       resp0_result,
  output logic                          resp1_valid,
  output logic [`VEC_XPR_LEN-1:0]       resp1_result,
  output logic                          md_req_valid,
  input  logic                          md_req_ready,
  output logic                          md_in_1_signed,
  output logic                          md_in_2_signed,
  output logic [`MD_OP_WIDTH-1:0]       md_op,
  output logic [`MD_OUT_SEL_WIDTH-1:0]  md_out_sel,
  output logic [`VEC_XPR_LEN-1:0]       md_in_1,
  output logic [`VEC_XPR_LEN-1:0]       md_in_2,
  input  logic                          md_resp_valid,
  input  logic [`VEC_XPR_LEN-1:0]       md_resp_result,
  output logic                          busy,
  output logic                          owner,
  output logic                          timeout_err
);

  localparam int unsigned XLEN = `VEC_XPR_LEN;
  localparam int unsigned OPW  = `MD_OP_WIDTH;
  localparam int unsigned OSW  = `MD_OUT_SEL_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic             r_owner;
  logic             r_timeout_err;
  logic [WDT_WIDTH-1:0] r_wdt;
  logic             r_md_req_valid;
  logic             r_md_in_1_signed;
  logic             r_md_in_2_signed;
  logic [OPW-1:0]   r_md_op;
  logic [OSW-1:0]   r_md_out_sel;
  logic [XLEN-1:0]  r_md_in_1;
  logic [XLEN-1:0]  r_md_in_2;
  logic [XLEN-1:0]  r_result;
  logic             r_resp0_valid;
  logic             r_resp1_valid;

  logic             w_idle;
  logic             w_any;
  logic             w_grant1;
  logic             w_wdt_expired;

  // Grant decode: port 1 wins when alone, or on contention when it holds priority
`ifdef XVEC2_MD_ARB_FIXED_PRIO_EN
  assign w_grant1 = req1_valid & ~req0_valid;
`else
  logic r_rr_ptr;
  assign w_grant1 = req1_valid & (~req0_valid | r_rr_ptr);
`endif

  assign w_idle        = (r_state == S_IDLE);
  assign w_any         = req0_valid | req1_valid;
  assign w_wdt_expired = (r_wdt == WDT_WIDTH'(WDT_CYCLES - 1));

  assign req0_ready = w_idle & w_any & ~w_grant1;
  assign req1_ready = w_idle & w_grant1;

  assign resp0_valid    = r_resp0_valid;
  assign resp1_valid    = r_resp1_valid;
  assign resp0_result   = r_result;
  assign resp1_result   = r_result;
  assign md_req_valid   = r_md_req_valid;
  assign md_in_1_signed = r_md_in_1_signed;
  assign md_in_2_signed = r_md_in_2_signed;
  assign md_op          = r_md_op;
  assign md_out_sel     = r_md_out_sel;
  assign md_in_1        = r_md_in_1;
  assign md_in_2        = r_md_in_2;
  assign busy           = ~w_idle;
  assign owner          = r_owner;
  assign timeout_err    = r_timeout_err;

  // Arbitration FSM: accept, issue to unit, wait with watchdog, pulse response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_owner          <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_wdt            <= '0;
      r_md_req_valid   <= 1'b0;
      r_md_in_1_signed <= 1'b0;
      r_md_in_2_signed <= 1'b0;
      r_md_op          <= '0;
      r_md_out_sel     <= '0;
      r_md_in_1        <= '0;
      r_md_in_2        <= '0;
      r_result         <= '0;
      r_resp0_valid    <= 1'b0;
      r_resp1_valid    <= 1'b0;
`ifndef XVEC2_MD_ARB_FIXED_PRIO_EN
      r_rr_ptr         <= 1'b0;
`endif
    end else begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            if (w_grant1) begin
              r_md_in_1_signed <= req1_in_1_signed;
              r_md_in_2_signed <= req1_in_2_signed;
              r_md_op          <= req1_op;
              r_md_out_sel     <= req1_out_sel;
              r_md_in_1        <= req1_in_1;
              r_md_in_2        <= req1_in_2;
            end else begin
              r_md_in_1_signed <= req0_in_1_signed;
              r_md_in_2_signed <= req0_in_2_signed;
              r_md_op          <= req0_op;
              r_md_out_sel     <= req0_out_sel;
              r_md_in_1        <= req0_in_1;
              r_md_in_2        <= req0_in_2;
            end
            r_owner        <= w_grant1;
            r_md_req_valid <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (md_req_ready) begin
            r_md_req_valid <= 1'b0;
            r_wdt          <= '0;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wdt <= r_wdt + WDT_WIDTH'(1);
          if (md_resp_valid) begin
            r_result      <= md_resp_result;
            r_resp0_valid <= ~r_owner;
            r_resp1_valid <= r_owner;
            r_state       <= S_RESP;
          end else if (w_wdt_expired) begin
            r_result      <= '0;
            r_timeout_err <= 1'b1;
            r_resp0_valid <= ~r_owner;
            r_resp1_valid <= r_owner;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
`ifndef XVEC2_MD_ARB_FIXED_PRIO_EN
          r_rr_ptr <= ~r_owner;
`endif
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xvec2_md_arbiter.sv
// tb_xvec2_md_arbiter: directed scoreboard bench for xvec2_md_arbiter with a
// behavioural 34-cycle mul/div unit stub that can be muted.

`ifndef VEC_XPR_LEN
`define VEC_XPR_LEN 64
`endif
`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`endif
`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`endif

module tb_xvec2_md_arbiter;

  localparam int unsigned XL  = `VEC_XPR_LEN;
  localparam int unsigned OPW = `MD_OP_WIDTH;
  localparam int unsigned OSW = `MD_OUT_SEL_WIDTH;
  localparam logic [OPW-1:0] OP_MUL = OPW'(0);
  localparam logic [OPW-1:0] OP_DIV = OPW'(1);
  localparam logic [OPW-1:0] OP_REM = OPW'(2);
  localparam logic [OSW-1:0] SEL_LO  = OSW'(0);
  localparam logic [OSW-1:0] SEL_HI  = OSW'(1);
  localparam logic [OSW-1:0] SEL_REM = OSW'(2);

  typedef struct packed {
    logic           s1;
    logic           s2;
    logic [OPW-1:0] op;
    logic [OSW-1:0] sel;
    logic [XL-1:0]  a;
    logic [XL-1:0]  b;
  } req_t;

  typedef struct {
    int            port;
    logic [XL-1:0] res;
  } exp_t;

  logic clk, reset;
  logic req0_valid, req0_ready, req0_in_1_signed, req0_in_2_signed;
  logic [OPW-1:0] req0_op;
  logic [OSW-1:0] req0_out_sel;
  logic [XL-1:0]  req0_in_1, req0_in_2;
  logic req1_valid, req1_ready, req1_in_1_signed, req1_in_2_signed;
  logic [OPW-1:0] req1_op;
  logic [OSW-1:0] req1_out_sel;
  logic [XL-1:0]  req1_in_1, req1_in_2;
  logic resp0_valid, resp1_valid;
  logic [XL-1:0] resp0_result, resp1_result;
  logic md_req_valid, md_req_ready, md_in_1_signed, md_in_2_signed;
  logic [OPW-1:0] md_op;
  logic [OSW-1:0] md_out_sel;
  logic [XL-1:0]  md_in_1, md_in_2;
  logic md_resp_valid;
  logic [XL-1:0] md_resp_result;
  logic busy, owner, timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int resp_cyc = 0;
  int n_resp = 0;
  exp_t exp_q[$];

  xvec2_md_arbiter #(.WDT_CYCLES(64), .WDT_WIDTH(7)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in_1_signed(req0_in_1_signed), .req0_in_2_signed(req0_in_2_signed),
    .req0_op(req0_op), .req0_out_sel(req0_out_sel),
    .req0_in_1(req0_in_1), .req0_in_2(req0_in_2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in_1_signed(req1_in_1_signed), .req1_in_2_signed(req1_in_2_signed),
    .req1_op(req1_op), .req1_out_sel(req1_out_sel),
    .req1_in_1(req1_in_1), .req1_in_2(req1_in_2),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_in_1_signed(md_in_1_signed), .md_in_2_signed(md_in_2_signed),
    .md_op(md_op), .md_out_sel(md_out_sel),
    .md_in_1(md_in_1), .md_in_2(md_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial md_req_ready = 1'b1;

  // Per-lane 32-bit reference arithmetic of the unit
  function automatic logic [XL-1:0] calc(input logic s1, input logic s2,
                                         input logic [OPW-1:0] op, input logic [OSW-1:0] sel,
                                         input logic [XL-1:0] a, input logic [XL-1:0] b);
    logic [XL-1:0] r;
    logic signed [32:0] xs, ys, q, m;
    logic signed [65:0] p;
    logic [31:0] v;
    r = '0;
    for (int l = 0; l < int'(XL / 32); l++) begin
      xs = $signed({s1 & a[l*32+31], a[l*32 +: 32]});
      ys = $signed({s2 & b[l*32+31], b[l*32 +: 32]});
      p  = xs * ys;
      q  = (ys == 0) ? -33'sd1 : xs / ys;
      m  = (ys == 0) ? xs : xs % ys;
      if (op == OP_MUL)                        v = (sel == SEL_HI) ? p[63:32] : p[31:0];
      else if (op == OP_REM || sel == SEL_REM) v = m[31:0];
      else                                     v = q[31:0];
      r[l*32 +: 32] = v;
    end
    return r;
  endfunction

  // Unit stub: accepts on handshake, answers 34 cycles later unless muted
  logic          stub_mute;
  logic          stub_busy;
  logic [5:0]    stub_cnt;
  logic [XL-1:0] stub_res;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_busy      <= 1'b0;
      stub_cnt       <= '0;
      stub_res       <= '0;
      md_resp_valid  <= 1'b0;
      md_resp_result <= '0;
    end else begin
      md_resp_valid <= 1'b0;
      if (!stub_busy && md_req_valid && md_req_ready && !stub_mute) begin
        stub_busy <= 1'b1;
        stub_cnt  <= '0;
        stub_res  <= calc(md_in_1_signed, md_in_2_signed, md_op, md_out_sel, md_in_1, md_in_2);
      end else if (stub_busy) begin
        if (stub_cnt == 6'd33) begin
          md_resp_valid  <= 1'b1;
          md_resp_result <= stub_res;
          stub_busy      <= 1'b0;
        end
        stub_cnt <= stub_cnt + 6'd1;
      end
    end
  end

  // Cycle counter and unit-handshake timestamp
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (md_req_valid && md_req_ready) hs_cyc <= cyc + 1;
  end

  // Monitor: protocol invariants and scoreboard compare on each response pulse
  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (!reset) begin
      if (req0_ready && req1_ready) begin
        checks++; failures++;
        $display("FAIL both_ready actual=11 required=at most one");
      end
      if ((req0_ready || req1_ready) && busy) begin
        checks++; failures++;
        $display("FAIL ready_while_busy actual=ready required=no ready");
      end
      if (resp0_valid || resp1_valid) begin
        p = resp1_valid ? 1 : 0;
        checks++;
        n_resp++;
        resp_cyc = cyc;
        if (resp0_valid && resp1_valid) begin
          failures++;
          $display("FAIL resp_both actual=both required=one port");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected actual=port%0d result=%h required=no response", p, p ? resp1_result : resp0_result);
        end else begin
          e = exp_q.pop_front();
          if (e.port != p || (p ? resp1_result : resp0_result) !== e.res || owner !== p[0]) begin
            failures++;
            $display("FAIL resp actual=port%0d owner=%0b result=%h required=port%0d result=%h",
                     p, owner, p ? resp1_result : resp0_result, e.port, e.res);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic req_t mk(input logic s1, input logic s2, input logic [OPW-1:0] op,
                              input logic [OSW-1:0] sel, input logic [XL-1:0] a, input logic [XL-1:0] b);
    req_t r;
    r.s1 = s1; r.s2 = s2; r.op = op; r.sel = sel; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic push(input int port, input logic [XL-1:0] res);
    exp_t e;
    e.port = port;
    e.res  = res;
    exp_q.push_back(e);
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic set_port(input int p, input logic v, input req_t r);
    if (p == 0) begin
      req0_valid = v; req0_in_1_signed = r.s1; req0_in_2_signed = r.s2;
      req0_op = r.op; req0_out_sel = r.sel; req0_in_1 = r.a; req0_in_2 = r.b;
    end else begin
      req1_valid = v; req1_in_1_signed = r.s1; req1_in_2_signed = r.s2;
      req1_op = r.op; req1_out_sel = r.sel; req1_in_1 = r.a; req1_in_2 = r.b;
    end
  endtask

  // Present a request and hold it until accepted (bounded)
  task automatic drive(input int p, input req_t r);
    bit done;
    done = 1'b0;
    @(negedge clk);
    set_port(p, 1'b1, r);
    for (int i = 0; i < 400 && !done; i++) begin
      #1;
      if (rdy(p)) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    set_port(p, 1'b0, r);
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout port%0d actual=no ready required=ready", p);
    end
  endtask

  // Wait until all expected responses are seen and the arbiter is idle (bounded)
  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    req_t z, a0, a1, b0, b1, c0, c1, d0;
    int nr;
    z = '0;
    stub_mute = 1'b0;
    reset = 1'b1;
    set_port(0, 1'b0, z);
    set_port(1, 1'b0, z);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",     XL'(busy),         '0);
    chk("rst_owner",    XL'(owner),        '0);
    chk("rst_tmo",      XL'(timeout_err),  '0);
    chk("rst_resp0_v",  XL'(resp0_valid),  '0);
    chk("rst_resp1_v",  XL'(resp1_valid),  '0);
    chk("rst_mdreq_v",  XL'(md_req_valid), '0);
    chk("rst_ready",    XL'({req0_ready, req1_ready}), '0);
    chk("rst_md_in_1",  md_in_1,           '0);
    chk("rst_result",   resp0_result,      '0);
    @(negedge clk);
    reset = 1'b0;

    // Port 0 signed MUL lanes {7,3}*{5,-2}
    push(0, {32'd35, 32'hFFFF_FFFA});
    drive(0, mk(1'b1, 1'b1, OP_MUL, SEL_LO, {32'd7, 32'd3}, {32'd5, 32'hFFFF_FFFE}));
    wait_idle("mul");
    chk("lat_mul", XL'(resp_cyc - hs_cyc), XL'(35));
    chk("tmo_clear", XL'(timeout_err), '0);

    // Port 0 unsigned MUL high half
    push(0, {32'd1, 32'd1});
    drive(0, mk(1'b0, 1'b0, OP_MUL, SEL_HI, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, {32'd2, 32'd2}));
    wait_idle("mulh");

    // Port 1 signed DIV and REM of -7 by 2
    push(1, {32'hFFFF_FFFD, 32'hFFFF_FFFD});
    drive(1, mk(1'b1, 1'b1, OP_DIV, SEL_LO, {32'hFFFF_FFF9, 32'hFFFF_FFF9}, {32'd2, 32'd2}));
    wait_idle("div");
    push(1, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    drive(1, mk(1'b1, 1'b1, OP_REM, SEL_LO, {32'hFFFF_FFF9, 32'hFFFF_FFF9}, {32'd2, 32'd2}));
    wait_idle("rem");

    // Silent unit: watchdog forces a zero result and sets the sticky flag
    stub_mute = 1'b1;
    push(0, '0);
    drive(0, mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd4, 32'd4}, {32'd4, 32'd4}));
    wait_idle("wdt");
    chk("wdt_lat", XL'(resp_cyc - hs_cyc), XL'(64));
    chk("wdt_tmo", XL'(timeout_err), XL'(1));
    stub_mute = 1'b0;
    push(1, {32'd12, 32'd12});
    drive(1, mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd3, 32'd3}, {32'd4, 32'd4}));
    wait_idle("post_wdt");
    chk("tmo_sticky", XL'(timeout_err), XL'(1));

    // Reset while waiting on the unit aborts silently
    drive(1, mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd5, 32'd5}, {32'd5, 32'd5}));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy",    XL'(busy),         '0);
    chk("abort_mdreq_v", XL'(md_req_valid), '0);
    chk("abort_resp_v",  XL'({resp0_valid, resp1_valid}), '0);
    chk("abort_tmo",     XL'(timeout_err),  '0);
    chk("abort_result",  resp1_result,      '0);
    @(negedge clk);
    reset = 1'b0;
    nr = n_resp;
    repeat (60) @(negedge clk);
    chk("abort_no_resp", XL'(n_resp), XL'(nr));

    // Contention right after reset, each port with two queued requests
    a0 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd2, 32'd2},     {32'd3, 32'd3});
    b0 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd1, 32'd1},     {32'd9, 32'd9});
    a1 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd4, 32'd4},     {32'd5, 32'd5});
    b1 = mk(1'b0, 1'b0, OP_DIV, SEL_LO, {32'd100, 32'd100}, {32'd10, 32'd10});
`ifdef XVEC2_MD_ARB_FIXED_PRIO_EN
    push(0, {32'd6, 32'd6});
    push(0, {32'd9, 32'd9});
    push(1, {32'd20, 32'd20});
    push(1, {32'd10, 32'd10});
`else
    push(0, {32'd6, 32'd6});
    push(1, {32'd20, 32'd20});
    push(0, {32'd9, 32'd9});
    push(1, {32'd10, 32'd10});
`endif
    fork
      begin drive(0, a0); drive(0, b0); end
      begin drive(1, a1); drive(1, b1); end
    join
    wait_idle("contend1");

    // Single port-0 op, then contention again
    c0 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd3, 32'd3}, {32'd3, 32'd3});
    push(0, {32'd9, 32'd9});
    drive(0, c0);
    wait_idle("single");
    c1 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd8, 32'd8}, {32'd8, 32'd8});
    d0 = mk(1'b0, 1'b0, OP_MUL, SEL_LO, {32'd7, 32'd7}, {32'd1, 32'd1});
`ifdef XVEC2_MD_ARB_FIXED_PRIO_EN
    push(0, {32'd7, 32'd7});
    push(1, {32'd64, 32'd64});
`else
    push(1, {32'd64, 32'd64});
    push(0, {32'd7, 32'd7});
`endif
    fork
      drive(0, d0);
      drive(1, c1);
    join
    wait_idle("contend2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
